mem_lsu: RTL and testbench

Parametrised load/store unit for the MEM stage, replacing the single-request path. It has a DEPTH-entry posted store buffer, one outstanding bus transaction, a stall on load-after-store hazards, and flush handling for exceptions. It sits between the MEM-stage control/datapath and the sram-like data bus. Address checking and CP0 stay outside the unit; only a misalignment flag is reported.

---
 rtl/mem_lsu.sv | 207 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a posted store buffer and a single
// outstanding sram-like bus transaction; loads stall on same-word buffered stores.
module mem_lsu #(
    parameter int DATA_W   = 32,
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              addr_err,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              m_stall,
    output logic              sb_empty,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam logic [PTR_W:0] SB_FULL = SB_DEPTH[PTR_W:0];

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_ADDR = 3'd1;
    localparam logic [2:0] S_LD_DATA = 3'd2;
    localparam logic [2:0] S_ST_ADDR = 3'd3;
    localparam logic [2:0] S_ST_DATA = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    sb_count_q, sb_count_d;

    logic [ADDR_W-1:0] sb_addr_q  [SB_DEPTH];
    logic [1:0]        sb_size_q  [SB_DEPTH];
    logic [DATA_W-1:0] sb_wdata_q [SB_DEPTH];

    logic              misalign, conflict, push, pop, ld_acc;
    logic [PTR_W-1:0]  rel;
    logic [1:0]        head_size;
    logic [DATA_W-1:0] head_wdata, wdata_rep;

    always_comb begin
        case (req_size)
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            2'd3:    misalign = (DATA_W == 32) ? 1'b1 : |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        conflict = 1'b0;
        rel      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rel = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, rel} < sb_count_q) &&
                (sb_addr_q[i][ADDR_W-1:OFF_W] == req_addr[ADDR_W-1:OFF_W]))
                conflict = 1'b1;
        end
    end

    always_comb begin
        req_ready = 1'b0;
        push      = 1'b0;
        ld_acc    = 1'b0;
        if (req_valid && !flush) begin
            if (misalign) begin
                req_ready = 1'b1;
            end else if (req_wr) begin
                push      = (sb_count_q != SB_FULL);
                req_ready = push;
            end else begin
                ld_acc    = (state_q == S_IDLE) && !conflict;
                req_ready = ld_acc;
            end
        end
    end

    assign addr_err = req_valid && misalign;
    assign m_stall  = req_valid && !req_ready;
    assign sb_empty = (sb_count_q == '0);

    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        pop        = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_acc)                state_d = S_LD_ADDR;
                else if (sb_count_q != '0) state_d = S_ST_ADDR;
            end
            S_LD_ADDR: begin
                if (data_addr_ok) begin
                    state_d = S_LD_DATA;
                    if (flush) discard_d = 1'b1;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_LD_DATA: begin
                if (data_data_ok) begin
                    resp_valid = !discard_q && !flush;
                    discard_d  = 1'b0;
                    state_d    = S_IDLE;
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            S_ST_ADDR: if (data_addr_ok) state_d = S_ST_DATA;
            S_ST_DATA: begin
                if (data_data_ok) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_addr_d  = ld_acc ? req_addr : ld_addr_q;
        ld_size_d  = ld_acc ? req_size : ld_size_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        sb_count_d = sb_count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            ld_addr_q  <= '0;
            ld_size_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sb_count_q <= '0;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            ld_addr_q  <= ld_addr_d;
            ld_size_q  <= ld_size_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sb_count_q <= sb_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_q[wr_ptr_q]  <= req_addr;
            sb_size_q[wr_ptr_q]  <= req_size;
            sb_wdata_q[wr_ptr_q] <= req_wdata;
        end
    end

    assign head_size  = sb_size_q[rd_ptr_q];
    assign head_wdata = sb_wdata_q[rd_ptr_q];

    always_comb begin
        wdata_rep = head_wdata;
        case (head_size)
            2'd0: for (int i = 0; i < DATA_W / 8; i++)  wdata_rep[i*8 +: 8]   = head_wdata[7:0];
            2'd1: for (int i = 0; i < DATA_W / 16; i++) wdata_rep[i*16 +: 16] = head_wdata[15:0];
            2'd2: for (int i = 0; i < DATA_W / 32; i++) wdata_rep[i*32 +: 32] = head_wdata[31:0];
            default: wdata_rep = head_wdata;
        endcase
    end

    always_comb begin
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = '0;
        data_addr  = '0;
        data_wdata = '0;
        if (state_q == S_LD_ADDR) begin
            data_req  = 1'b1;
            data_size = ld_size_q;
            data_addr = ld_addr_q;
        end else if (state_q == S_ST_ADDR) begin
            data_req   = 1'b1;
            data_wr    = 1'b1;
            data_size  = head_size;
            data_addr  = sb_addr_q[rd_ptr_q];
            data_wdata = wdata_rep;
        end
    end

    assign resp_rdata = resp_valid ? (data_rdata >> {ld_addr_q[OFF_W-1:0], 3'b000}) : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios with literal expectations plus random
// traffic compared every cycle against a transaction-level model.
module tb_mem_lsu;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, addr_err, resp_valid, m_stall, sb_empty;
    logic [31:0] resp_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;

    int checks = 0;
    int failures = 0;

    mem_lsu #(.DATA_W(32), .SB_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .addr_err(addr_err), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .m_stall(m_stall), .sb_empty(sb_empty),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rep(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Transaction-level model: a queue of buffered stores and at most one bus transaction.
    typedef struct { logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; } ent_t;
    ent_t        m_sb[$];
    logic        m_busy = 0, m_load = 0, m_aph = 0, m_disc = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [1:0]  m_size = 0;
    logic        mis, conf, e_ready, e_push, e_ld, e_resp;

    always @(negedge clk) begin
        if (rst) begin
            m_sb.delete();
            m_busy = 0; m_disc = 0; m_aph = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_data_req", data_req, 0);
            chk("rst_sb_empty", sb_empty, 1);
        end else begin
            mis  = misal(req_size, req_addr);
            conf = 0;
            foreach (m_sb[i]) if (m_sb[i].addr[31:2] == req_addr[31:2]) conf = 1;
            e_ready = 0; e_push = 0; e_ld = 0;
            if (req_valid && !flush) begin
                if (mis) e_ready = 1;
                else if (req_wr) begin e_ready = (m_sb.size() < DEPTH); e_push = e_ready; end
                else begin e_ready = !m_busy && !conf; e_ld = e_ready; end
            end
            e_resp = m_busy && m_load && !m_aph && data_data_ok && !m_disc && !flush;
            chk("req_ready", req_ready, e_ready);
            chk("addr_err", addr_err, req_valid && mis);
            chk("m_stall", m_stall, req_valid && !e_ready);
            chk("sb_empty", sb_empty, m_sb.size() == 0);
            chk("data_req", data_req, m_busy && m_aph);
            chk("data_wr", data_wr, m_busy && m_aph && !m_load);
            chk("data_addr", data_addr, (m_busy && m_aph) ? m_addr : 32'h0);
            chk("data_size", data_size, (m_busy && m_aph) ? m_size : 2'd0);
            chk("data_wdata", data_wdata, (m_busy && m_aph && !m_load) ? rep(m_size, m_wdata) : 32'h0);
            chk("resp_valid", resp_valid, e_resp);
            chk("resp_rdata", resp_rdata, e_resp ? (data_rdata >> (8 * m_addr[1:0])) : 32'h0);
            if (!m_busy) begin
                if (e_ld) begin
                    m_busy = 1; m_load = 1; m_aph = 1; m_addr = req_addr; m_size = req_size; m_wdata = 0;
                end else if (m_sb.size() > 0) begin
                    m_busy = 1; m_load = 0; m_aph = 1;
                    m_addr = m_sb[0].addr; m_size = m_sb[0].size; m_wdata = m_sb[0].wdata;
                end
            end else if (m_aph) begin
                if (data_addr_ok) begin
                    m_aph = 0;
                    if (m_load && flush) m_disc = 1;
                end else if (m_load && flush) begin
                    m_busy = 0;
                end
            end else begin
                if (data_data_ok) begin
                    m_busy = 0; m_disc = 0;
                    if (!m_load) void'(m_sb.pop_front());
                end else if (m_load && flush) begin
                    m_disc = 1;
                end
            end
            if (e_push) m_sb.push_back('{req_addr, req_size, req_wdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
    endtask

    task automatic wait_req(input int maxc);
        int n = 0;
        while (!data_req && n < maxc) begin tick(); n++; end
        chk("wait_data_req", data_req, 1);
    endtask

    task automatic drain_one(input logic [31:0] exp_addr);
        wait_req(20);
        chk("drain_addr", data_addr, exp_addr);
        data_addr_ok = 1; tick(); data_addr_ok = 0;
        data_data_ok = 1; tick(); data_data_ok = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic        f, rv;
        logic [1:0]  sz;
        logic [31:0] a;
        repeat (2) tick();
        rst = 0;
        #1;
        chk("init_sb_empty", sb_empty, 1);
        chk("init_data_req", data_req, 0);
        chk("init_resp_valid", resp_valid, 0);
        tick();

        // Byte load from 0x203
        drive_req(0, 2'd0, 32'h203, 0); #1 chk("t4_acc", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("t4_req", data_req, 1); chk("t4_size", data_size, 0); chk("t4_addr", data_addr, 32'h203);
        data_addr_ok = 1; tick(); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'h11223344; #1;
        chk("t4_resp_valid", resp_valid, 1); chk("t4_rdata", resp_rdata, 32'h11);
        tick(); data_data_ok = 0;

        // Misaligned load, then half store replication
        drive_req(0, 2'd2, 32'h302, 0); #1;
        chk("t5_addr_err", addr_err, 1); chk("t5_ready", req_ready, 1);
        tick(); chk("t5_no_req", data_req, 0);
        drive_req(1, 2'd1, 32'h306, 32'h5566); #1 chk("t5_st_acc", req_ready, 1);
        tick(); req_valid = 0;
        wait_req(5);
        chk("t5_wdata", data_wdata, 32'h55665566); chk("t5_size", data_size, 1); chk("t5_wr", data_wr, 1);
        drain_one(32'h306);

        // Four stores fill the buffer, fifth stalls through the pop cycle
        for (int i = 0; i < 4; i++) begin
            drive_req(1, 2'd2, 32'h100 + 32'(4 * i), 32'(i)); #1 chk("t2_acc", req_ready, 1);
            tick();
        end
        drive_req(1, 2'd2, 32'h110, 32'h55); #1 chk("t2_full_stall", m_stall, 1);
        repeat (3) begin tick(); chk("t2_hold_stall", m_stall, 1); end
        chk("t2_head_addr", data_addr, 32'h100);
        data_addr_ok = 1; tick(); data_addr_ok = 0; #1 chk("t2_st_data_stall", m_stall, 1);
        data_data_ok = 1; #1 chk("t2_pop_cycle_stall", m_stall, 1);
        tick(); data_data_ok = 0; #1 chk("t2_fifth_acc", req_ready, 1);
        tick(); req_valid = 0;
        drain_one(32'h104); drain_one(32'h108); drain_one(32'h10C); drain_one(32'h110);
        chk("t2_empty", sb_empty, 1);

        // Load-after-store hazard
        drive_req(1, 2'd2, 32'h200, 32'hDEADBEEF); #1 chk("t3_st_acc", req_ready, 1);
        tick();
        drive_req(0, 2'd2, 32'h200, 0); #1 chk("t3_ld_stall", m_stall, 1);
        tick(); chk("t3_stall2", m_stall, 1); chk("t3_st_wdata", data_wdata, 32'hDEADBEEF);
        data_addr_ok = 1; tick(); data_addr_ok = 0; #1 chk("t3_stall3", m_stall, 1);
        data_data_ok = 1; #1 chk("t3_stall_pop", m_stall, 1);
        tick(); data_data_ok = 0; #1 chk("t3_ld_acc", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("t3_ld_addr", data_addr, 32'h200); chk("t3_ld_wr", data_wr, 0);
        data_addr_ok = 1; tick(); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'hDEADBEEF; #1;
        chk("t3_resp", resp_valid, 1); chk("t3_rdata", resp_rdata, 32'hDEADBEEF);
        tick(); data_data_ok = 0;

        // Flush in LD_ADDR before addr_ok drops the request
        drive_req(0, 2'd2, 32'h480, 0); #1 chk("t6a_acc", req_ready, 1);
        tick(); req_valid = 0;
        flush = 1; #1 chk("t6a_req_hi", data_req, 1);
        tick(); flush = 0; #1 chk("t6a_req_dropped", data_req, 0);

        // Flush in LD_DATA discards the late response
        drive_req(0, 2'd2, 32'h400, 0); #1 chk("t6_ld_acc", req_ready, 1);
        tick(); req_valid = 0;
        data_addr_ok = 1; tick(); data_addr_ok = 0;
        flush = 1; drive_req(1, 2'd2, 32'h404, 32'h1); #1 chk("t6_flush_blocks", req_ready, 0);
        tick(); flush = 0; req_valid = 0;
        tick(); tick();
        data_data_ok = 1; data_rdata = 32'hCAFEF00D; #1 chk("t6_discard", resp_valid, 0);
        tick(); data_data_ok = 0;
        drive_req(0, 2'd2, 32'h404, 0); #1 chk("t6_ld2_acc", req_ready, 1);
        tick(); req_valid = 0;
        data_addr_ok = 1; tick(); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'h12345678; #1;
        chk("t6_resp", resp_valid, 1); chk("t6_rdata", resp_rdata, 32'h12345678);
        tick(); data_data_ok = 0;

        // Asynchronous reset while waiting on a load's data phase
        drive_req(0, 2'd2, 32'h500, 0); #1 chk("t1_ld_acc", req_ready, 1);
        tick(); req_valid = 0;
        data_addr_ok = 1; tick(); data_addr_ok = 0;
        drive_req(1, 2'd2, 32'h600, 32'h77); #1 chk("t1_st_acc", req_ready, 1);
        tick(); req_valid = 0; #1 chk("t1_sb_full1", sb_empty, 0);
        data_data_ok = 1; data_rdata = 32'hA5A5A5A5; #1 chk("t1_pre_resp", resp_valid, 1);
        rst = 1; #1;
        chk("t1_resp_off", resp_valid, 0); chk("t1_sb_empty", sb_empty, 1);
        chk("t1_data_req", data_req, 0); chk("t1_rdata", resp_rdata, 0);
        data_data_ok = 0;
        tick(); rst = 0;
        tick(); chk("t1_post_idle", data_req, 0); chk("t1_post_empty", sb_empty, 1);

        // Random traffic around a small address window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            f  = ($urandom_range(0, 11) == 0);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            rv = ($urandom_range(0, 9) < 7);
            if (f && misal(sz, a)) rv = 0;
            req_valid = rv; req_wr = 1'($urandom_range(0, 1)); req_size = sz;
            req_addr = a; req_wdata = $urandom;
            flush = f;
            data_addr_ok = 1'($urandom_range(0, 1));
            data_data_ok = f ? 1'b0 : 1'($urandom_range(0, 1));
            data_rdata = $urandom;
            tick();
        end
        req_valid = 0; flush = 0; data_addr_ok = 1; data_data_ok = 1;
        repeat (40) tick();
        data_addr_ok = 0; data_data_ok = 0;
        tick();
        chk("final_sb_empty", sb_empty, 1);
        chk("final_data_req", data_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
